// File: rtl/uart_alu_interface.sv
// Command sequencer between uart_rx and the ALU/uart_tx pair: collects operand A,
// operand B and opcode, presents them to the ALU, and ships the result to uart_tx.
module uart_alu_interface #(
    parameter int N_DATA        = 8,
    parameter int NB_OP         = 6,
    parameter int TIMEOUT_TICKS = 16384,
    parameter int NB_TIMER      = 15
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_tick,
    input  logic [N_DATA-1:0] i_rx_data,
    input  logic              i_rx_done,
    input  logic [N_DATA-1:0] i_alu_result,
    input  logic              i_tx_done,
    output logic [N_DATA-1:0] o_data_a,
    output logic [N_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]  o_op,
    output logic [N_DATA-1:0] o_tx_data,
    output logic              o_tx_start,
    output logic              o_timeout,
    output logic              o_overrun
);

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;

    localparam logic [NB_TIMER-1:0] TIMER_LAST = NB_TIMER'(TIMEOUT_TICKS - 1);

    logic [2:0]          r_state;
    logic [NB_TIMER-1:0] r_timer;
    logic [N_DATA-1:0]   r_data_a;
    logic [N_DATA-1:0]   r_data_b;
    logic [NB_OP-1:0]    r_op;
    logic [N_DATA-1:0]   r_tx_data;
    logic                r_tx_start;
    logic                r_timeout;
    logic                r_overrun;

    logic w_timeout_hit;
    logic w_busy;

    assign w_timeout_hit = i_tick && (r_timer == TIMER_LAST);
    assign w_busy        = (r_state == ST_SEND) || (r_state == ST_WAIT_TX);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_WAIT_A;
            r_timer    <= '0;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_op       <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make the strobes one-cycle pulses; any
            // branch below that raises one overrides this default for that edge.
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= i_rx_done && w_busy;

            case (r_state)
                ST_WAIT_A: begin
                    if (i_rx_done) begin
                        r_data_a <= i_rx_data;
                        r_timer  <= '0;
                        r_state  <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    // A byte arriving on the expiring tick still counts.
                    if (i_rx_done) begin
                        r_data_b <= i_rx_data;
                        r_timer  <= '0;
                        r_state  <= ST_WAIT_OP;
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_timer   <= '0;
                        r_state   <= ST_WAIT_A;
                    end else if (i_tick) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_WAIT_OP: begin
                    if (i_rx_done) begin
                        r_op    <= i_rx_data[NB_OP-1:0];
                        r_timer <= '0;
                        r_state <= ST_SEND;
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_timer   <= '0;
                        r_state   <= ST_WAIT_A;
                    end else if (i_tick) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_SEND: begin
                    // o_op settled a full cycle ago, so the ALU output is stable.
                    r_tx_data  <= i_alu_result;
                    r_tx_start <= 1'b1;
                    r_state    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        r_state <= ST_WAIT_A;
                    end
                end
                default: begin
                    r_state <= ST_WAIT_A;
                end
            endcase
        end
    end

    assign o_data_a   = r_data_a;
    assign o_data_b   = r_data_b;
    assign o_op       = r_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_timeout  = r_timeout;
    assign o_overrun  = r_overrun;

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Command sequencer between `uart_rx` and the ALU/`uart_tx` pair. It collects three received bytes in order: operand A, operand B, opcode. It holds them as stable ALU inputs, captures the ALU result and hands it to `uart_tx` with a one-cycle start strobe. An inter-byte timeout, counted in baud ticks, discards a partial command so the host can resynchronise.

## Interface
Parameters:
- `N_DATA`, 8, width of a UART data byte, operands and result.
- `NB_OP`, 6, opcode width; taken from the low `NB_OP` bits of the third byte.
- `TIMEOUT_TICKS`, 16384, number of `i_tick` pulses allowed between bytes of one command.
- `NB_TIMER`, 15, timeout counter width; must satisfy 2^NB_TIMER > TIMEOUT_TICKS.

Ports (one clock; reset is asynchronous and active-low):
- `i_clock`  in  1  system clock, all state on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_tick`  in  1  baud-rate tick, the same strobe that feeds `uart_rx` `i_valid`.
- `i_rx_data`  in  N_DATA  received byte from `uart_rx` `o_data`.
- `i_rx_done`  in  1  one-cycle byte-ready pulse from `uart_rx` `rx_done`.
- `i_alu_result`  in  N_DATA  combinational ALU output.
- `i_tx_done`  in  1  one-cycle pulse from `uart_tx` when a byte has left the line.
- `o_data_a`  out  N_DATA  registered operand A to ALU.
- `o_data_b`  out  N_DATA  registered operand B to ALU.
- `o_op`  out  NB_OP  registered opcode to ALU.
- `o_tx_data`  out  N_DATA  registered byte for `uart_tx`.
- `o_tx_start`  out  1  one-cycle start strobe for `uart_tx`.
- `o_timeout`  out  1  one-cycle pulse: partial command discarded.
- `o_overrun`  out  1  one-cycle pulse: byte received while busy, dropped.

## Operation
- Reset (`i_reset`=0, asynchronous): state `WAIT_A`. All outputs 0, timer 0.
- `WAIT_A`: on `i_rx_done`, `o_data_a`<=`i_rx_data`, clear timer, go to `WAIT_B`. Ticks are ignored in this state; there is no timeout here.
- `WAIT_B`: on `i_rx_done`, `o_data_b`<=`i_rx_data`, clear timer, go to `WAIT_OP`. Otherwise each `i_tick` increments the timer.
- `WAIT_OP`: on `i_rx_done`, `o_op`<=`i_rx_data[NB_OP-1:0]`, go to `SEND`. Otherwise `i_tick` increments the timer.
- Timeout: in `WAIT_B`/`WAIT_OP`, when an `i_tick` arrives with timer == TIMEOUT_TICKS-1, do the following:
  - pulse `o_timeout`;
  - clear the timer and go to `WAIT_A`;
  - leave `o_data_a`/`o_data_b`/`o_op` unchanged.
- `i_rx_done` and the timeout tick in the same cycle: the byte wins and is accepted normally, with no `o_timeout`.
- `SEND` (exactly one cycle, giving the ALU a full settle cycle): `o_tx_data`<=`i_alu_result`, `o_tx_start`<=1, go to `WAIT_TX`.
- `WAIT_TX`: wait for `i_tx_done`, then go to `WAIT_A`. `i_tx_done` in any other state is ignored.
- `i_rx_done` in `SEND` or `WAIT_TX`: the byte is dropped, `o_overrun` pulses for one cycle, and the state is unaffected.
- `o_data_a`/`o_data_b`/`o_op` hold until overwritten by the next command's corresponding byte.
- `o_tx_data` holds until the next `SEND`.

## Timing
- All outputs are registered; none are combinational from inputs.
- Opcode `i_rx_done` sampled at edge n:
  - `o_op` is valid after edge n.
  - `o_tx_data` and `o_tx_start`=1 are valid after edge n+1.
  - `o_tx_start` returns to 0 after edge n+2.
- `i_alu_result` is sampled at edge n+1 and must be stable by then, one full cycle after `o_op` changes.
- `o_timeout` and `o_overrun` are high for exactly one cycle, following the causing edge.
- Earliest next command byte accepted: the cycle after `i_tx_done` is sampled.
- Reset asserted mid-command or mid-`WAIT_TX`: immediate return to `WAIT_A` with all outputs 0. After deassertion, the first `i_rx_done` is treated as operand A.

## Test plan
- Normal add: bytes 0x05, 0x03, 0x20; bench ALU gives A+B.
  - `o_data_a`=0x05, `o_data_b`=0x03, `o_op`=0x20.
  - `o_tx_data`=0x08, with a single `o_tx_start` two edges after the opcode `rx_done`.
- Opcode masking: third byte 0xE2 -> `o_op`=0x22.
- Timeout: send 0x11, then TIMEOUT_TICKS ticks with no byte.
  - One `o_timeout` pulse, state `WAIT_A`.
  - The next bytes 0x02, 0x02, 0x20 produce `o_tx_data`=0x04.
- Timeout race: `i_rx_done` coincides with the timeout tick in `WAIT_B`.
  - The byte is latched into `o_data_b` and there is no `o_timeout`.
- Overrun: `i_rx_done` with byte 0x77 during `WAIT_TX`.
  - One `o_overrun` pulse; `o_data_a` is unchanged.
  - After `i_tx_done`, the next byte becomes operand A.
- Reset mid-command: assert `i_reset`=0 in `WAIT_OP`.
  - All outputs are 0 asynchronously, with no `o_tx_start`.
  - After release, 0x01, 0x01, 0x20 produce `o_tx_data`=0x02.
